// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-lane data memory.
package ram_pkg;

  typedef enum logic {RW_READ_FIRST, RW_WRITE_FIRST} rw_mode_e;
  typedef enum logic {ST_INIT, ST_READY} ram_state_e;

  // One byte lane of a strobed merge: the new byte wins where its strobe is set.
  function automatic logic [7:0] byte_merge(
    input logic [7:0] old_byte,
    input logic [7:0] new_byte,
    input logic       strb
  );
    return strb ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/ram_read_pipe.sv
// Optional second read register stage: data and valid, synchronous reset.
module ram_read_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;

  // Data only advances with a valid result so rdata holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else begin
      valid_reg <= in_valid;
      if (in_valid) begin
        data_reg <= in_data;
      end
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;

endmodule

// File: rtl/byte_ram.sv
// Simple dual-port RAM with byte strobes, 1- or 2-cycle reads, selectable
// read-during-write policy and a zero-fill sweep after reset.
module byte_ram
  import ram_pkg::*;
#(
  parameter int       MEM_WIDTH    = 32,
  parameter int       MEM_DEPTH    = 256,
  parameter int       READ_LATENCY = 1,
  parameter rw_mode_e RW_MODE      = RW_READ_FIRST,
  localparam int      ADDR_WIDTH   = $clog2(MEM_DEPTH),
  localparam int      NUM_BYTES    = MEM_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [NUM_BYTES-1:0]  wstrb,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [MEM_WIDTH-1:0]  wdata,
  input  logic                  ren,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [MEM_WIDTH-1:0]  rdata,
  output logic                  rvalid,
  output logic                  ready
);

  if (MEM_WIDTH % 8 != 0) begin : g_err_width
    $error("byte_ram: MEM_WIDTH must be a multiple of 8");
  end
  if (MEM_DEPTH < 2 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_err_depth
    $error("byte_ram: MEM_DEPTH must be a power of 2 and at least 2");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_err_lat
    $error("byte_ram: READ_LATENCY must be 1 or 2");
  end

  ram_state_e            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;

  logic [MEM_WIDTH-1:0]  mem [MEM_DEPTH];
  logic [MEM_WIDTH-1:0]  rd1_reg;
  logic                  rv1_reg;
  logic [MEM_WIDTH-1:0]  old_word;
  logic [MEM_WIDTH-1:0]  merged_word;
  logic [MEM_WIDTH-1:0]  rd_word;
  logic                  init_wr;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  collide;

  // ---------------- control FSM and sweep counter ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ready      = 1'b0;
    case (state_reg)
      ST_INIT: begin
        cnt_next = cnt_reg + 1'b1;
        // Depth is a power of two, so the all-ones address is the last word.
        if (cnt_reg == '1) begin
          state_next = ST_READY;
        end
      end
      ST_READY: begin
        ready = 1'b1;
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  // Requests are only honoured once the sweep is finished and outside reset.
  assign init_wr = !rst && (state_reg == ST_INIT);
  assign wr_fire = !rst && (state_reg == ST_READY) && wen;
  assign rd_fire = !rst && (state_reg == ST_READY) && ren;
  assign collide = wr_fire && (waddr == raddr);

  // ---------------- memory array, byte-lane writes ----------------
  always_ff @(posedge clk) begin
    if (init_wr) begin
      mem[cnt_reg] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wstrb[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // ---------------- read-during-write resolution ----------------
  assign old_word = mem[raddr];

  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
    assign merged_word[8*gi +: 8] = byte_merge(old_word[8*gi +: 8],
                                               wdata[8*gi +: 8], wstrb[gi]);
  end

  always_comb begin
    rd_word = old_word;
    if (RW_MODE == RW_WRITE_FIRST && collide) begin
      rd_word = merged_word;
    end
  end

  // ---------------- first read register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rv1_reg <= 1'b0;
      rd1_reg <= '0;
    end else begin
      rv1_reg <= rd_fire;
      if (rd_fire) begin
        rd1_reg <= rd_word;
      end
    end
  end

  // ---------------- optional second stage ----------------
  if (READ_LATENCY == 2) begin : g_pipe2
    ram_read_pipe #(
      .WIDTH (MEM_WIDTH)
    ) u_read_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (rv1_reg),
      .in_data   (rd1_reg),
      .out_valid (rvalid),
      .out_data  (rdata)
    );
  end else begin : g_pipe1
    assign rvalid = rv1_reg;
    assign rdata  = rd1_reg;
  end

endmodule

// File: tb/tb_byte_ram.sv
// Directed bench: two instances share stimulus, one read-first with 1-cycle
// reads, one write-first with 2-cycle reads.
module tb_byte_ram;
  import ram_pkg::*;

  logic        clk;
  logic        rst;
  logic        wen;
  logic [3:0]  wstrb;
  logic [7:0]  waddr;
  logic [31:0] wdata;
  logic        ren;
  logic [7:0]  raddr;

  logic [31:0] rdata_a, rdata_b;
  logic        rvalid_a, rvalid_b;
  logic        ready_a, ready_b;

  int total;
  int bad;

  byte_ram #(
    .MEM_WIDTH    (32),
    .MEM_DEPTH    (256),
    .READ_LATENCY (1),
    .RW_MODE      (RW_READ_FIRST)
  ) dut_a (
    .clk    (clk),
    .rst    (rst),
    .wen    (wen),
    .wstrb  (wstrb),
    .waddr  (waddr),
    .wdata  (wdata),
    .ren    (ren),
    .raddr  (raddr),
    .rdata  (rdata_a),
    .rvalid (rvalid_a),
    .ready  (ready_a)
  );

  byte_ram #(
    .MEM_WIDTH    (32),
    .MEM_DEPTH    (256),
    .READ_LATENCY (2),
    .RW_MODE      (RW_WRITE_FIRST)
  ) dut_b (
    .clk    (clk),
    .rst    (rst),
    .wen    (wen),
    .wstrb  (wstrb),
    .waddr  (waddr),
    .wdata  (wdata),
    .ren    (ren),
    .raddr  (raddr),
    .rdata  (rdata_b),
    .rvalid (rvalid_b),
    .ready  (ready_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
    wen = 1'b1; waddr = addr; wdata = data; wstrb = strb;
    tick();
    wen = 1'b0;
    $display("write addr=%0d data=%h strb=%b", addr, data, strb);
  endtask

  task automatic read_word(input logic [7:0] addr, input logic [31:0] exp);
    ren = 1'b1; raddr = addr;
    tick();
    ren = 1'b0;
    check("a_rvalid_l1", 32'(rvalid_a), 32'd1);
    check("b_rvalid_early", 32'(rvalid_b), 32'd0);
    check("a_rdata", rdata_a, exp);
    tick();
    check("a_rvalid_pulse", 32'(rvalid_a), 32'd0);
    check("b_rvalid_l2", 32'(rvalid_b), 32'd1);
    check("b_rdata", rdata_b, exp);
    $display("read addr=%0d a=%h b=%h exp=%h", addr, rdata_a, rdata_b, exp);
  endtask

  // Counts cycles from reset release to ready; pokes addr 3 mid-sweep.
  task automatic wait_ready(input string tag);
    int n;
    logic saw_rv;
    n = 0;
    saw_rv = 1'b0;
    while (!ready_a && n < 400) begin
      wen   = (n >= 10 && n < 13);
      ren   = (n >= 10 && n < 13);
      waddr = 8'd3; raddr = 8'd3;
      wdata = 32'h12345678; wstrb = 4'hF;
      tick();
      n++;
      if (rvalid_a || rvalid_b) saw_rv = 1'b1;
    end
    wen = 1'b0; ren = 1'b0;
    check({tag, "_ready_cycles"}, 32'(n), 32'd256);
    check({tag, "_ready_b"}, 32'(ready_b), 32'd1);
    check({tag, "_no_rvalid"}, 32'(saw_rv), 32'd0);
    $display("sweep %s done after %0d cycles", tag, n);
  endtask

  logic [31:0] vals [3];

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; wen = 1'b0; ren = 1'b0;
    wstrb = '0; waddr = '0; wdata = '0; raddr = '0;
    tick();
    tick();
    check("rst_rdata_a", rdata_a, 32'h0);
    check("rst_rdata_b", rdata_b, 32'h0);
    check("rst_rvalid", {30'd0, rvalid_a, rvalid_b}, 32'd0);
    check("rst_ready", {30'd0, ready_a, ready_b}, 32'd0);
    rst = 1'b0;

    // Sweep, with requests to addr 3 that must be ignored
    wait_ready("init");
    for (int a = 0; a < 256; a++) read_word(8'(a), 32'h0);

    // Byte strobes, and an all-zero strobe write
    write_word(8'd5, 32'hAABBCCDD, 4'hF);
    write_word(8'd5, 32'h11223344, 4'b0101);
    read_word(8'd5, 32'hAA22CC44);
    write_word(8'd5, 32'hFFFFFFFF, 4'b0000);
    read_word(8'd5, 32'hAA22CC44);

    // Back-to-back reads of 1,2,3
    vals[0] = 32'h01010101; vals[1] = 32'h02020202; vals[2] = 32'h03030303;
    for (int k = 0; k < 3; k++) write_word(8'(k + 1), vals[k], 4'hF);
    for (int s = 0; s < 6; s++) begin
      ren = (s < 3); raddr = 8'(s + 1);
      tick();
      check("pipe_a_rvalid", 32'(rvalid_a), (s < 3) ? 32'd1 : 32'd0);
      check("pipe_b_rvalid", 32'(rvalid_b), (s >= 1 && s <= 3) ? 32'd1 : 32'd0);
      if (s < 3) check("pipe_a_rdata", rdata_a, vals[s]);
      if (s >= 1 && s <= 3) check("pipe_b_rdata", rdata_b, vals[s-1]);
      $display("pipe cycle=%0d a=%b/%h b=%b/%h", s, rvalid_a, rdata_a, rvalid_b, rdata_b);
    end
    ren = 1'b0;

    // Same-address collision on addr 9 (zero from sweep)
    wen = 1'b1; waddr = 8'd9; wdata = 32'hDEADBEEF; wstrb = 4'b0011;
    ren = 1'b1; raddr = 8'd9;
    tick();
    wen = 1'b0; ren = 1'b0;
    check("coll_a_rvalid", 32'(rvalid_a), 32'd1);
    check("coll_read_first", rdata_a, 32'h0);
    tick();
    check("coll_b_rvalid", 32'(rvalid_b), 32'd1);
    check("coll_write_first", rdata_b, 32'h0000BEEF);
    $display("collision a=%h b=%h", rdata_a, rdata_b);
    read_word(8'd9, 32'h0000BEEF);

    // Different addresses in the same cycle do not interact
    wen = 1'b1; waddr = 8'd10; wdata = 32'h12345678; wstrb = 4'hF;
    ren = 1'b1; raddr = 8'd9;
    tick();
    wen = 1'b0; ren = 1'b0;
    check("diff_a_rdata", rdata_a, 32'h0000BEEF);
    tick();
    check("diff_b_rdata", rdata_b, 32'h0000BEEF);
    $display("diff-addr a=%h b=%h", rdata_a, rdata_b);
    read_word(8'd10, 32'h12345678);

    // Reset while a read is in flight
    read_word(8'd5, 32'hAA22CC44);
    ren = 1'b1; raddr = 8'd5;
    tick();
    ren = 1'b0; rst = 1'b1;
    wen = 1'b1; waddr = 8'd7; wdata = 32'hCAFEF00D; wstrb = 4'hF;
    tick();
    wen = 1'b0;
    check("mid_rst_rvalid_a", 32'(rvalid_a), 32'd0);
    check("mid_rst_rvalid_b", 32'(rvalid_b), 32'd0);
    check("mid_rst_rdata_a", rdata_a, 32'h0);
    check("mid_rst_rdata_b", rdata_b, 32'h0);
    check("mid_rst_ready", {30'd0, ready_a, ready_b}, 32'd0);
    $display("reset mid-read a=%h b=%h", rdata_a, rdata_b);
    rst = 1'b0;
    wait_ready("rerun");
    read_word(8'd5, 32'h0);
    read_word(8'd10, 32'h0);
    read_word(8'd3, 32'h0);
    read_word(8'd7, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
